// File: rtl/mem_array_ctrl_pkg.sv
// Shared types and defaults for the memory-array access controller.
// The state encoding is fixed so the controller can mirror it as plain logic constants.
package mem_array_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;
    localparam int ROWS       = 2**ADDR_W_DEF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WL   = 3'd2,
        S_DONE = 3'd3,
        S_VPRE = 3'd4,
        S_VWL  = 3'd5
    } state_e;

endpackage

// File: rtl/mem_array_ctrl_if.sv
// Host request/response and array-side signals of the access controller.
// slave = controller side; master = host plus array model side.
interface mem_array_ctrl_if
    import mem_array_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   arr_pre;
    logic [2**ADDR_W-1:0]   arr_sel;
    logic                   arr_we;
    logic [DATA_W-1:0]      arr_wdata;
    logic                   arr_sense;
    logic [DATA_W-1:0]      arr_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, arr_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               arr_pre, arr_sel, arr_we, arr_wdata, arr_sense
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, arr_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               arr_pre, arr_sel, arr_we, arr_wdata, arr_sense
    );

endinterface

// File: rtl/mem_array_ctrl_row_decoder.sv
// Registered one-hot word-line decoder: o_sel follows i_en/i_addr one cycle later.
// Cleared asynchronously so word lines drop the instant reset asserts.
module mem_row_decoder
    import mem_array_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [2**ADDR_W-1:0]  o_sel
);
    localparam int N_ROWS = 2**ADDR_W;

    logic [N_ROWS-1:0] r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (i_en) begin
            r_sel <= N_ROWS'(1) << i_addr;
        end else begin
            r_sel <= '0;
        end
    end

    assign o_sel = r_sel;

endmodule

// File: rtl/mem_array_ctrl.sv
// Single-access sequencer for the row array: precharge, word line, then write-drive or sense; rsp_valid PRE_CYC+WL_CYC+1 cycles after accept.
// req_ready only in IDLE; MEM_ARRAY_CTRL_WRITE_VERIFY_EN adds a precharge+read-back verify pass after writes.
module mem_array_ctrl
    import mem_array_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRE_CYC = 1,
    parameter int WL_CYC  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_array_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE = S_IDLE;
    localparam logic [2:0] ST_PRE  = S_PRE;
    localparam logic [2:0] ST_WL   = S_WL;
    localparam logic [2:0] ST_DONE = S_DONE;
    localparam logic [2:0] ST_VPRE = S_VPRE;
    localparam logic [2:0] ST_VWL  = S_VWL;

    localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               w_cnt_zero;
    logic               w_accept;
    logic               w_wl_nxt;
    logic               w_arr_we;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.req_valid) w_state_nxt = ST_PRE;
            ST_PRE:  if (w_cnt_zero)    w_state_nxt = ST_WL;
            ST_WL: begin
                if (w_cnt_zero) begin
`ifdef MEM_ARRAY_CTRL_WRITE_VERIFY_EN
                    w_state_nxt = r_we ? ST_VPRE : ST_DONE;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_VPRE: if (w_cnt_zero)    w_state_nxt = ST_VWL;
            ST_VWL:  if (w_cnt_zero)    w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter reloads on every phase change and only counts down within a phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                if ((w_state_nxt == ST_WL) || (w_state_nxt == ST_VWL)) begin
                    r_cnt <= CNT_W'(WL_CYC - 1);
                end else begin
                    r_cnt <= CNT_W'(PRE_CYC - 1);
                end
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == ST_WL && w_cnt_zero && !r_we) begin
            r_rdata <= bus.arr_rdata;
`ifdef MEM_ARRAY_CTRL_WRITE_VERIFY_EN
        end else if (r_state == ST_VWL && w_cnt_zero) begin
            r_rdata <= bus.arr_rdata;
`endif
        end
    end

`ifdef MEM_ARRAY_CTRL_WRITE_VERIFY_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == ST_VWL && w_cnt_zero) begin
            r_err <= (bus.arr_rdata != r_wdata);
        end
    end

    assign bus.rsp_err = (r_state == ST_DONE) && r_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Word lines are registered, so the decoder is fed the upcoming state.
    assign w_wl_nxt = (w_state_nxt == ST_WL) || (w_state_nxt == ST_VWL);

    mem_row_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_wl_nxt),
        .i_addr (r_addr),
        .o_sel  (bus.arr_sel)
    );

    assign w_arr_we      = (r_state == ST_WL) && r_we;
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_DONE);
    assign bus.rsp_rdata = r_rdata;
    assign bus.arr_pre   = (r_state == ST_PRE) || (r_state == ST_VPRE);
    assign bus.arr_we    = w_arr_we;
    assign bus.arr_wdata = w_arr_we ? r_wdata : '0;
    assign bus.arr_sense = ((r_state == ST_WL) && !r_we) || (r_state == ST_VWL);

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Directed bench for mem_array_ctrl: default-timing instance with a row-array model, plus a PRE_CYC=2/WL_CYC=3 instance.
module tb_mem_array_ctrl;
    import mem_array_pkg::*;

`ifdef MEM_ARRAY_CTRL_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_array_ctrl_if #(.ADDR_W(3), .DATA_W(4)) ia ();
    mem_array_ctrl_if #(.ADDR_W(3), .DATA_W(4)) ib ();

    mem_array_ctrl #(.ADDR_W(3), .DATA_W(4), .PRE_CYC(1), .WL_CYC(2)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    mem_array_ctrl #(.ADDR_W(3), .DATA_W(4), .PRE_CYC(2), .WL_CYC(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    int checks = 0;
    int failures = 0;
    int cur_idx = 0;

    logic [3:0] mem [8];
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'h0;
    logic [3:0] a_rd;

    always_comb begin
        a_rd = 4'h0;
        for (int r = 0; r < 8; r++) if (ia.arr_sel[r]) a_rd = mem[r];
        ia.arr_rdata = force_en ? force_val : a_rd;
    end

    always @(posedge clk) begin
        for (int r = 0; r < 8; r++) if (ia.arr_we && ia.arr_sel[r]) mem[r] <= ia.arr_wdata;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((ia.arr_pre && |ia.arr_sel) || (ia.arr_we && ia.arr_sense) || !$onehot0(ia.arr_sel)) begin
                failures++;
                $display("FAIL invariant_a pre=%0b sel=%02h we=%0b sense=%0b", ia.arr_pre, ia.arr_sel, ia.arr_we, ia.arr_sense);
            end
            checks++;
            if ((ib.arr_pre && |ib.arr_sel) || (ib.arr_we && ib.arr_sense) || !$onehot0(ib.arr_sel)) begin
                failures++;
                $display("FAIL invariant_b pre=%0b sel=%02h we=%0b sense=%0b", ib.arr_pre, ib.arr_sel, ib.arr_we, ib.arr_sense);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%0h required=%0h", nm, cur_idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input logic we, input logic [2:0] addr, input logic [3:0] wdata,
                              input logic [7:0] exp_sel, input logic [3:0] exp_rd,
                              input int exp_lat, input logic exp_err);
        int lat;
        chk("ready_idle", ia.req_ready, 1);
        ia.req_valid = 1'b1; ia.req_we = we; ia.req_addr = addr; ia.req_wdata = wdata;
        tick();
        ia.req_valid = 1'b0;
        chk("pre_c1", ia.arr_pre, 1);
        chk("sel_c1", ia.arr_sel, 0);
        chk("ready_c1", ia.req_ready, 0);
        tick();
        chk("sel_c2", ia.arr_sel, exp_sel);
        chk("we_c2", ia.arr_we, we);
        chk("sense_c2", ia.arr_sense, !we);
        if (we) chk("wdata_c2", ia.arr_wdata, wdata);
        tick();
        chk("sel_c3", ia.arr_sel, exp_sel);
        lat = 0;
        for (int k = 4; k <= 12; k++) begin
            tick();
            if (ia.rsp_valid) begin lat = k; break; end
        end
        chk("latency", lat, exp_lat);
        chk("rsp_rdata", ia.rsp_rdata, exp_rd);
        chk("rsp_err", ia.rsp_err, exp_err);
        tick();
        chk("rsp_pulse", ia.rsp_valid, 0);
    endtask

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [3:0] wdata;
        logic [7:0] exp_sel;
        logic [3:0] exp_rdata;
    } vec_t;

    vec_t vt [17];

    initial begin
        int acc [3];
        int n, rdy_bad, npre, nsel, lat, vlat, npulse;
        logic got, drop;
        logic [3:0] last_rd, exp_rd;

        vt[0]  = '{1'b1, 3'd5, 4'hA, 8'h20, 4'hA};
        vt[1]  = '{1'b1, 3'd0, 4'h1, 8'h01, 4'h1};
        vt[2]  = '{1'b1, 3'd1, 4'h2, 8'h02, 4'h2};
        vt[3]  = '{1'b1, 3'd2, 4'h3, 8'h04, 4'h3};
        vt[4]  = '{1'b1, 3'd3, 4'h4, 8'h08, 4'h4};
        vt[5]  = '{1'b1, 3'd4, 4'h5, 8'h10, 4'h5};
        vt[6]  = '{1'b1, 3'd5, 4'h6, 8'h20, 4'h6};
        vt[7]  = '{1'b1, 3'd6, 4'h7, 8'h40, 4'h7};
        vt[8]  = '{1'b1, 3'd7, 4'h8, 8'h80, 4'h8};
        vt[9]  = '{1'b0, 3'd0, 4'h0, 8'h01, 4'h1};
        vt[10] = '{1'b0, 3'd1, 4'h0, 8'h02, 4'h2};
        vt[11] = '{1'b0, 3'd2, 4'h0, 8'h04, 4'h3};
        vt[12] = '{1'b0, 3'd3, 4'h0, 8'h08, 4'h4};
        vt[13] = '{1'b0, 3'd4, 4'h0, 8'h10, 4'h5};
        vt[14] = '{1'b0, 3'd5, 4'h0, 8'h20, 4'h6};
        vt[15] = '{1'b0, 3'd6, 4'h0, 8'h40, 4'h7};
        vt[16] = '{1'b0, 3'd7, 4'h0, 8'h80, 4'h8};

        ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = '0; ia.req_wdata = '0;
        ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = '0; ib.req_wdata = '0;
        ib.arr_rdata = 4'h5;

        #12;
        cur_idx = -1;
        chk("rst_ready", ia.req_ready, 1);
        chk("rst_rsp_valid", ia.rsp_valid, 0);
        chk("rst_pre", ia.arr_pre, 0);
        chk("rst_sel", ia.arr_sel, 0);
        chk("rst_we", ia.arr_we, 0);
        chk("rst_sense", ia.arr_sense, 0);
        chk("rst_rdata", ia.rsp_rdata, 0);
        chk("rst_err", ia.rsp_err, 0);
        #10 rst_n = 1'b1;
        tick();

        last_rd = 4'h0;
        for (int i = 0; i < 17; i++) begin
            cur_idx = i;
            exp_rd = (vt[i].we && !VERIFY) ? last_rd : vt[i].exp_rdata;
            run_access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_sel, exp_rd,
                       (vt[i].we && VERIFY) ? 7 : 4, 1'b0);
            last_rd = exp_rd;
        end

        // Back-to-back reads of rows 1,2,3 with req_valid held high.
        cur_idx = 100;
        acc[0] = -100; acc[1] = -100; acc[2] = -100;
        n = 0; drop = 1'b0;
        ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_addr = 3'd1;
        for (int cyc = 0; cyc < 30 && !drop; cyc++) begin
            if (ia.req_ready) begin acc[n] = cyc; n++; end
            tick();
            if (n == 3) begin ia.req_valid = 1'b0; drop = 1'b1; end
            else ia.req_addr = 3'(n + 1);
        end
        ia.req_valid = 1'b0;
        chk("b2b_gap01", acc[1] - acc[0], 5);
        chk("b2b_gap12", acc[2] - acc[1], 5);
        got = 1'b0; rdy_bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (ia.rsp_valid) begin got = 1'b1; break; end
            if (ia.req_ready) rdy_bad++;
            tick();
        end
        chk("b2b_rsp", got, 1);
        chk("b2b_ready_low", rdy_bad, 0);
        chk("b2b_rdata", ia.rsp_rdata, 4'h4);
        tick();

        // Reset in the middle of the word-line phase of a write to row 3.
        cur_idx = 200;
        ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 3'd3; ia.req_wdata = 4'h9;
        tick();
        ia.req_valid = 1'b0;
        tick();
        chk("mid_we_before", ia.arr_we, 1);
        chk("mid_sel_before", ia.arr_sel, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_we_async", ia.arr_we, 0);
        chk("mid_sel_async", ia.arr_sel, 0);
        chk("mid_pre_async", ia.arr_pre, 0);
        chk("mid_ready_rst", ia.req_ready, 1);
        #13 rst_n = 1'b1;
        tick();
        chk("mid_ready_after", ia.req_ready, 1);
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            if (ia.rsp_valid) npulse++;
            tick();
        end
        chk("mid_no_rsp", npulse, 0);

        // Write-verify: forced bad read-back, then a clean one.
        cur_idx = 300;
        vlat = VERIFY ? 7 : 4;
        force_en = 1'b1; force_val = 4'h8;
        run_access(1'b1, 3'd2, 4'hC, 8'h04, VERIFY ? 4'h8 : 4'h0, vlat, VERIFY);
        force_en = 1'b0;
        cur_idx = 301;
        run_access(1'b1, 3'd2, 4'hC, 8'h04, VERIFY ? 4'hC : 4'h0, vlat, 1'b0);

        // Longer phases on the second instance.
        cur_idx = 400;
        chk("b_ready", ib.req_ready, 1);
        ib.req_valid = 1'b1; ib.req_we = 1'b0; ib.req_addr = 3'd6;
        tick();
        ib.req_valid = 1'b0;
        npre = 0; nsel = 0; lat = 0;
        for (int k = 1; k <= 12; k++) begin
            if (ib.rsp_valid) begin lat = k; break; end
            if (ib.arr_pre) npre++;
            if (ib.arr_sel == 8'h40) nsel++;
            tick();
        end
        chk("b_pre_cycles", npre, 2);
        chk("b_sel_cycles", nsel, 3);
        chk("b_latency", lat, 6);
        chk("b_rdata", ib.rsp_rdata, 4'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
